// File: rtl/id_pipe_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_pipe_stage_pkg
// Shared constants for the RV64I/RV32I decode stage:
//   - one-hot inst_type codes
//   - RISC-V major opcode, funct3 and funct7 values
//   - operand-select enums driven by the decoder into the stage's operand mux
//   - immediate sign-extension helper
// -----------------------------------------------------------------------------
package id_pipe_stage_pkg;

    // One-hot instruction classes seen by the execute stage
    localparam logic [4:0] TYPE_NONE  = 5'b00000;
    localparam logic [4:0] TYPE_ARITH = 5'b10000;
    localparam logic [4:0] TYPE_LOGIC = 5'b01000;
    localparam logic [4:0] TYPE_LS    = 5'b00100;
    localparam logic [4:0] TYPE_JUMP  = 5'b00010;
    localparam logic [4:0] TYPE_SYS   = 5'b00001;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Load/store width funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Branch funct3 holes (everything else is a defined compare)
    localparam logic [2:0] F3_BR_RSV0 = 3'b010;
    localparam logic [2:0] F3_BR_RSV1 = 3'b011;

    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_RS1  = 2'd1,
        OP1_PC   = 2'd2
    } op1_sel_e;

    typedef enum logic [1:0] {
        OP2_ZERO = 2'd0,
        OP2_RS2  = 2'd1,
        OP2_IMM  = 2'd2
    } op2_sel_e;

    // Sign-extend a 12-bit I/S immediate to the widest datapath
    function automatic logic [63:0] sext12(input logic [11:0] v);
        return {{52{v[11]}}, v};
    endfunction

endpackage

// File: rtl/id_pipe_stage_decoder.sv
// -----------------------------------------------------------------------------
// id_decoder
// Purely combinational instruction decoder.
// Ports:
//   inst        in   32-bit instruction word
//   inst_type   out  one-hot class (0 when illegal)
//   inst_opcode out  {opcode[6:2], funct3}
//   op_alt      out  inst[30] for sub/sra/srai/srli, else 0
//   imm         out  sign-extended immediate of the format, else 0
//   rs1_ena     out  instruction reads rs1
//   rs2_ena     out  instruction reads rs2
//   rd_ena      out  instruction writes rd (before the x0 check)
//   illegal     out  encoding not supported for this XLEN
//   op1_sel     out  operand-1 source select
//   op2_sel     out  operand-2 source select
// -----------------------------------------------------------------------------
module id_decoder
    import id_pipe_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    output logic [4:0]      inst_type,
    output logic [7:0]      inst_opcode,
    output logic            op_alt,
    output logic [XLEN-1:0] imm,
    output logic            rs1_ena,
    output logic            rs2_ena,
    output logic            rd_ena,
    output logic            illegal,
    output op1_sel_e        op1_sel,
    output op2_sel_e        op2_sel
);

    localparam logic IS_RV64 = (XLEN == 64);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [63:0] imm_i_s;
    logic [63:0] imm_st_s;
    logic [63:0] imm_b_s;
    logic [63:0] imm_u_s;
    logic [63:0] imm_j_s;
    logic        shamt_ok_s;

    logic [4:0]  type_raw_s;
    logic        alt_raw_s;
    logic [63:0] imm_raw_s;
    logic        rs1_raw_s;
    logic        rs2_raw_s;
    logic        rd_raw_s;
    logic        legal_s;
    op1_sel_e    op1_raw_s;
    op2_sel_e    op2_raw_s;

    assign opcode_s = inst[6:0];
    assign funct3_s = inst[14:12];
    assign funct7_s = inst[31:25];

    assign imm_i_s  = sext12(inst[31:20]);
    assign imm_st_s = sext12({inst[31:25], inst[11:7]});
    assign imm_b_s  = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u_s  = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign imm_j_s  = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    // shamt[5] (inst[25]) only exists on RV64
    assign shamt_ok_s = IS_RV64 | ~inst[25];

    // Format/class decode; legality is folded in afterwards
    always_comb begin
        type_raw_s = TYPE_NONE;
        alt_raw_s  = 1'b0;
        imm_raw_s  = 64'd0;
        rs1_raw_s  = 1'b0;
        rs2_raw_s  = 1'b0;
        rd_raw_s   = 1'b0;
        legal_s    = 1'b0;
        op1_raw_s  = OP1_ZERO;
        op2_raw_s  = OP2_ZERO;
        case (opcode_s)
            OPC_OP_IMM: begin
                rs1_raw_s = 1'b1;
                rd_raw_s  = 1'b1;
                op1_raw_s = OP1_RS1;
                op2_raw_s = OP2_IMM;
                imm_raw_s = imm_i_s;
                case (funct3_s)
                    F3_ADD_SUB, F3_SLT, F3_SLTU: begin
                        type_raw_s = TYPE_ARITH;
                        legal_s    = 1'b1;
                    end
                    F3_XOR, F3_OR, F3_AND: begin
                        type_raw_s = TYPE_LOGIC;
                        legal_s    = 1'b1;
                    end
                    F3_SLL: begin
                        type_raw_s = TYPE_LOGIC;
                        legal_s    = (inst[31:26] == 6'd0) & shamt_ok_s;
                    end
                    F3_SR: begin
                        // inst[30] picks srai over srli; all other upper bits must be 0
                        type_raw_s = TYPE_LOGIC;
                        alt_raw_s  = inst[30];
                        legal_s    = ~inst[31] & (inst[29:26] == 4'd0) & shamt_ok_s;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_OP: begin
                rs1_raw_s = 1'b1;
                rs2_raw_s = 1'b1;
                rd_raw_s  = 1'b1;
                op1_raw_s = OP1_RS1;
                op2_raw_s = OP2_RS2;
                case (funct3_s)
                    F3_ADD_SUB: begin
                        type_raw_s = TYPE_ARITH;
                        alt_raw_s  = inst[30];
                        legal_s    = (funct7_s == F7_BASE) | (funct7_s == F7_ALT);
                    end
                    F3_SLT, F3_SLTU: begin
                        type_raw_s = TYPE_ARITH;
                        legal_s    = (funct7_s == F7_BASE);
                    end
                    F3_SLL, F3_XOR, F3_OR, F3_AND: begin
                        type_raw_s = TYPE_LOGIC;
                        legal_s    = (funct7_s == F7_BASE);
                    end
                    F3_SR: begin
                        type_raw_s = TYPE_LOGIC;
                        alt_raw_s  = inst[30];
                        legal_s    = (funct7_s == F7_BASE) | (funct7_s == F7_ALT);
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                type_raw_s = TYPE_ARITH;
                rd_raw_s   = 1'b1;
                op1_raw_s  = (opcode_s == OPC_AUIPC) ? OP1_PC : OP1_ZERO;
                op2_raw_s  = OP2_IMM;
                imm_raw_s  = imm_u_s;
                legal_s    = 1'b1;
            end
            OPC_LOAD: begin
                type_raw_s = TYPE_LS;
                rs1_raw_s  = 1'b1;
                rd_raw_s   = 1'b1;
                op1_raw_s  = OP1_RS1;
                imm_raw_s  = imm_i_s;
                case (funct3_s)
                    F3_B, F3_H, F3_W, F3_BU, F3_HU: legal_s = 1'b1;
                    F3_D, F3_WU:                    legal_s = IS_RV64;
                    default:                        legal_s = 1'b0;
                endcase
            end
            OPC_STORE: begin
                type_raw_s = TYPE_LS;
                rs1_raw_s  = 1'b1;
                rs2_raw_s  = 1'b1;
                op1_raw_s  = OP1_RS1;
                op2_raw_s  = OP2_RS2;
                imm_raw_s  = imm_st_s;
                case (funct3_s)
                    F3_B, F3_H, F3_W: legal_s = 1'b1;
                    F3_D:             legal_s = IS_RV64;
                    default:          legal_s = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                type_raw_s = TYPE_JUMP;
                rs1_raw_s  = 1'b1;
                rs2_raw_s  = 1'b1;
                op1_raw_s  = OP1_RS1;
                op2_raw_s  = OP2_RS2;
                imm_raw_s  = imm_b_s;
                legal_s    = (funct3_s != F3_BR_RSV0) & (funct3_s != F3_BR_RSV1);
            end
            OPC_JAL: begin
                type_raw_s = TYPE_JUMP;
                rd_raw_s   = 1'b1;
                op1_raw_s  = OP1_PC;
                imm_raw_s  = imm_j_s;
                legal_s    = 1'b1;
            end
            OPC_JALR: begin
                type_raw_s = TYPE_JUMP;
                rs1_raw_s  = 1'b1;
                rd_raw_s   = 1'b1;
                op1_raw_s  = OP1_RS1;
                imm_raw_s  = imm_i_s;
                legal_s    = (funct3_s == F3_JALR);
            end
            OPC_SYSTEM: begin
                type_raw_s = TYPE_SYS;
                legal_s    = (inst == INST_ECALL) | (inst == INST_EBREAK);
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Illegal encodings are neutralised so they never read, write or stall
    assign illegal     = ~legal_s;
    assign inst_type   = legal_s ? type_raw_s : TYPE_NONE;
    assign inst_opcode = {opcode_s[6:2], funct3_s};
    assign op_alt      = legal_s & alt_raw_s;
    assign imm         = legal_s ? imm_raw_s[XLEN-1:0] : {XLEN{1'b0}};
    assign rs1_ena     = legal_s & rs1_raw_s;
    assign rs2_ena     = legal_s & rs2_raw_s;
    assign rd_ena      = legal_s & rd_raw_s;
    assign op1_sel     = legal_s ? op1_raw_s : OP1_ZERO;
    assign op2_sel     = legal_s ? op2_raw_s : OP2_ZERO;

endmodule

// File: rtl/id_pipe_stage.sv
// -----------------------------------------------------------------------------
// id_pipe_stage
// Registered instruction-decode stage between fetch and execute.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   in_valid/in_ready            fetch-side handshake (inst, pc)
//   flush                        kill stage contents, discard offered input
//   rs*_r_ena/rs*_r_addr         combinational regfile read port
//   rs*_data                     regfile read data (same cycle)
//   ex_load_valid/ex_load_rd     load in EX, for load-use stall
//   out_valid/out_ready          execute-side handshake
//   inst_type..illegal           registered decode result
// -----------------------------------------------------------------------------
module id_pipe_stage
    import id_pipe_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int TYPE_W = 5,
    parameter int OPC_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   pc,
    input  logic              flush,
    output logic              rs1_r_ena,
    output logic              rs2_r_ena,
    output logic [4:0]        rs1_r_addr,
    output logic [4:0]        rs2_r_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              ex_load_valid,
    input  logic [4:0]        ex_load_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TYPE_W-1:0] inst_type,
    output logic [OPC_W-1:0]  inst_opcode,
    output logic              op_alt,
    output logic [XLEN-1:0]   op1,
    output logic [XLEN-1:0]   op2,
    output logic [XLEN-1:0]   imm,
    output logic              rd_w_ena,
    output logic [4:0]        rd_w_addr,
    output logic [XLEN-1:0]   pc_out,
    output logic              illegal
);

    logic [4:0]      dec_type_s;
    logic [7:0]      dec_opcode_s;
    logic            dec_alt_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            dec_rs1_ena_s;
    logic            dec_rs2_ena_s;
    logic            dec_rd_ena_s;
    logic            dec_illegal_s;
    op1_sel_e        dec_op1_sel_s;
    op2_sel_e        dec_op2_sel_s;

    logic [XLEN-1:0] op1_s;
    logic [XLEN-1:0] op2_s;
    logic            adv_s;
    logic            stall_s;
    logic            rs1_hit_s;
    logic            rs2_hit_s;

    id_decoder #(
        .XLEN (XLEN)
    ) u_decoder (
        .inst        (inst),
        .inst_type   (dec_type_s),
        .inst_opcode (dec_opcode_s),
        .op_alt      (dec_alt_s),
        .imm         (dec_imm_s),
        .rs1_ena     (dec_rs1_ena_s),
        .rs2_ena     (dec_rs2_ena_s),
        .rd_ena      (dec_rd_ena_s),
        .illegal     (dec_illegal_s),
        .op1_sel     (dec_op1_sel_s),
        .op2_sel     (dec_op2_sel_s)
    );

    assign rs1_r_ena  = dec_rs1_ena_s;
    assign rs2_r_ena  = dec_rs2_ena_s;
    assign rs1_r_addr = dec_rs1_ena_s ? inst[19:15] : 5'd0;
    assign rs2_r_addr = dec_rs2_ena_s ? inst[24:20] : 5'd0;

    // Load-use: a load to x0 never produces a value worth waiting for
    assign rs1_hit_s = rs1_r_ena & (rs1_r_addr == ex_load_rd);
    assign rs2_hit_s = rs2_r_ena & (rs2_r_addr == ex_load_rd);
    assign stall_s   = in_valid & ex_load_valid & (ex_load_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);

    assign adv_s    = ~out_valid | out_ready;
    // During flush the offered input is swallowed, so the stage always takes it
    assign in_ready = rst_n & (flush | (adv_s & ~stall_s));

    // Operand-1 source mux
    always_comb begin
        op1_s = {XLEN{1'b0}};
        case (dec_op1_sel_s)
            OP1_RS1: op1_s = rs1_data;
            OP1_PC:  op1_s = pc;
            default: op1_s = {XLEN{1'b0}};
        endcase
    end

    // Operand-2 source mux
    always_comb begin
        op2_s = {XLEN{1'b0}};
        case (dec_op2_sel_s)
            OP2_RS2: op2_s = rs2_data;
            OP2_IMM: op2_s = dec_imm_s;
            default: op2_s = {XLEN{1'b0}};
        endcase
    end

    // Pipeline register: reset, flush, load, bubble or hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            inst_type   <= {TYPE_W{1'b0}};
            inst_opcode <= {OPC_W{1'b0}};
            op_alt      <= 1'b0;
            op1         <= {XLEN{1'b0}};
            op2         <= {XLEN{1'b0}};
            imm         <= {XLEN{1'b0}};
            rd_w_ena    <= 1'b0;
            rd_w_addr   <= 5'd0;
            pc_out      <= {XLEN{1'b0}};
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv_s) begin
            if (in_valid && !stall_s) begin
                out_valid   <= 1'b1;
                inst_type   <= dec_type_s;
                inst_opcode <= dec_opcode_s;
                op_alt      <= dec_alt_s;
                op1         <= op1_s;
                op2         <= op2_s;
                imm         <= dec_imm_s;
                rd_w_ena    <= dec_rd_ena_s & (inst[11:7] != 5'd0);
                rd_w_addr   <= dec_rd_ena_s ? inst[11:7] : 5'd0;
                pc_out      <= pc;
                illegal     <= dec_illegal_s;
            end else begin
                // Nothing offered or load-use stall: register a bubble
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_id_pipe_stage
// Directed bench for id_pipe_stage: one RV64 instance carries the main
// sequence, an RV32 instance sees the same stimulus and is checked where the
// two widths decode differently.
// -----------------------------------------------------------------------------
module tb_id_pipe_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        flush;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        out_ready;

    logic        in_ready, rs1_r_ena, rs2_r_ena, out_valid, op_alt, rd_w_ena, illegal;
    logic [4:0]  rs1_r_addr, rs2_r_addr, rd_w_addr, inst_type;
    logic [7:0]  inst_opcode;
    logic [63:0] op1, op2, imm, pc_out;

    logic        in_ready32, rs1_r_ena32, rs2_r_ena32, out_valid32, op_alt32, rd_w_ena32, illegal32;
    logic [4:0]  rs1_r_addr32, rs2_r_addr32, rd_w_addr32, inst_type32;
    logic [7:0]  inst_opcode32;
    logic [31:0] op1_32, op2_32, imm32, pc_out32;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_pipe_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .flush(flush),
        .rs1_r_ena(rs1_r_ena), .rs2_r_ena(rs2_r_ena),
        .rs1_r_addr(rs1_r_addr), .rs2_r_addr(rs2_r_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .inst_type(inst_type), .inst_opcode(inst_opcode), .op_alt(op_alt),
        .op1(op1), .op2(op2), .imm(imm),
        .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr), .pc_out(pc_out), .illegal(illegal)
    );

    id_pipe_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .inst(inst), .pc(pc[31:0]), .flush(flush),
        .rs1_r_ena(rs1_r_ena32), .rs2_r_ena(rs2_r_ena32),
        .rs1_r_addr(rs1_r_addr32), .rs2_r_addr(rs2_r_addr32),
        .rs1_data(rs1_data[31:0]), .rs2_data(rs2_data[31:0]),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid32), .out_ready(out_ready),
        .inst_type(inst_type32), .inst_opcode(inst_opcode32), .op_alt(op_alt32),
        .op1(op1_32), .op2(op2_32), .imm(imm32),
        .rd_w_ena(rd_w_ena32), .rd_w_addr(rd_w_addr32), .pc_out(pc_out32), .illegal(illegal32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset, with an instruction already offered -------
        rst_n = 1'b0; in_valid = 1'b1; inst = 32'hFFF1_0093; pc = 64'h8000_0000;
        rs1_data = 64'd5; rs2_data = 64'd0; flush = 1'b0;
        ex_load_valid = 1'b0; ex_load_rd = 5'd0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 64'd0);
        tick();
        chk("rst1_out_valid", out_valid, 64'd0);
        tick();
        chk("rst2_out_valid", out_valid, 64'd0);
        chk("rst_inst_type", inst_type, 64'd0);
        chk("rst_op1", op1, 64'd0);
        chk("rst_op2", op2, 64'd0);
        chk("rst_imm", imm, 64'd0);
        chk("rst_rd_w_ena", rd_w_ena, 64'd0);
        chk("rst_pc_out", pc_out, 64'd0);
        chk("rst_illegal", illegal, 64'd0);
        chk("rst_out_valid32", out_valid32, 64'd0);

        // ---------------- addi x1,x2,-1 ------------------------------------
        rst_n = 1'b1;
        #1;
        chk("addi_in_ready", in_ready, 64'd1);
        chk("addi_rs1_ena", rs1_r_ena, 64'd1);
        chk("addi_rs1_addr", rs1_r_addr, 64'd2);
        chk("addi_rs2_ena", rs2_r_ena, 64'd0);
        chk("addi_rs2_addr", rs2_r_addr, 64'd0);
        tick();
        chk("addi_out_valid", out_valid, 64'd1);
        chk("addi_type", inst_type, 64'h10);
        chk("addi_opcode", inst_opcode, 64'h20);
        chk("addi_op1", op1, 64'd5);
        chk("addi_op2", op2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd_w_ena", rd_w_ena, 64'd1);
        chk("addi_rd_w_addr", rd_w_addr, 64'd1);
        chk("addi_pc_out", pc_out, 64'h8000_0000);
        chk("addi_illegal", illegal, 64'd0);

        // ---------------- backpressure: sub x3,x4,x5 offered ---------------
        inst = 32'h4052_01B3; rs1_data = 64'd11; rs2_data = 64'd4; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_in_ready", in_ready, 64'd0);
            tick();
            chk("hold_out_valid", out_valid, 64'd1);
            chk("hold_op1", op1, 64'd5);
            chk("hold_op2", op2, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("hold_rd_w_addr", rd_w_addr, 64'd1);
            chk("hold_opcode", inst_opcode, 64'h20);
        end
        out_ready = 1'b1;
        #1;
        chk("sub_in_ready", in_ready, 64'd1);
        tick();
        chk("sub_out_valid", out_valid, 64'd1);
        chk("sub_type", inst_type, 64'h10);
        chk("sub_opcode", inst_opcode, 64'h60);
        chk("sub_op_alt", op_alt, 64'd1);
        chk("sub_op1", op1, 64'd11);
        chk("sub_op2", op2, 64'd4);
        chk("sub_imm", imm, 64'd0);
        chk("sub_rd_w_addr", rd_w_addr, 64'd3);

        // ---------------- load-use stall: add x7,x5,x1 ---------------------
        inst = 32'h0012_83B3; rs1_data = 64'd100; rs2_data = 64'd23;
        ex_load_valid = 1'b1; ex_load_rd = 5'd5;
        #1;
        chk("stall_rs1_in_ready", in_ready, 64'd0);
        tick();
        chk("stall_rs1_bubble", out_valid, 64'd0);
        ex_load_rd = 5'd1;
        #1;
        chk("stall_rs2_in_ready", in_ready, 64'd0);
        tick();
        chk("stall_rs2_bubble", out_valid, 64'd0);
        ex_load_valid = 1'b0;
        #1;
        chk("unstall_in_ready", in_ready, 64'd1);
        tick();
        chk("add_out_valid", out_valid, 64'd1);
        chk("add_op1", op1, 64'd100);
        chk("add_op2", op2, 64'd23);
        chk("add_op_alt", op_alt, 64'd0);
        chk("add_rd_w_addr", rd_w_addr, 64'd7);

        // ---------------- load to x0 never stalls: addi x1,x0,7 ------------
        inst = 32'h0070_0093; rs1_data = 64'd0; ex_load_valid = 1'b1; ex_load_rd = 5'd0;
        #1;
        chk("x0_in_ready", in_ready, 64'd1);
        tick();
        chk("x0_out_valid", out_valid, 64'd1);
        chk("x0_op2", op2, 64'd7);
        ex_load_valid = 1'b0;

        // ---------------- flush while valid & stalled downstream -----------
        inst = 32'h8000_0097; pc = 64'h1000; flush = 1'b1; out_ready = 1'b0;
        #1;
        chk("flush_in_ready", in_ready, 64'd1);
        tick();
        chk("flush_out_valid", out_valid, 64'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("flush_discard", out_valid, 64'd0);

        // ---------------- auipc x1,0x80000 ---------------------------------
        in_valid = 1'b1;
        tick();
        chk("auipc_out_valid", out_valid, 64'd1);
        chk("auipc_type", inst_type, 64'h10);
        chk("auipc_op1", op1, 64'h1000);
        chk("auipc_op2", op2, 64'hFFFF_FFFF_8000_0000);
        chk("auipc_imm", imm, 64'hFFFF_FFFF_8000_0000);

        // ---------------- sd x2,8(x1) --------------------------------------
        inst = 32'h0020_B423; rs1_data = 64'h2000; rs2_data = 64'hDEAD;
        tick();
        chk("sd_type", inst_type, 64'h04);
        chk("sd_op1", op1, 64'h2000);
        chk("sd_op2", op2, 64'hDEAD);
        chk("sd_imm", imm, 64'd8);
        chk("sd_rd_w_ena", rd_w_ena, 64'd0);
        chk("sd_illegal", illegal, 64'd0);
        chk("sd32_out_valid", out_valid32, 64'd1);
        chk("sd32_illegal", illegal32, 64'd1);

        // ---------------- ld x1,0(x2) --------------------------------------
        inst = 32'h0001_3083; rs1_data = 64'h3000;
        tick();
        chk("ld_type", inst_type, 64'h04);
        chk("ld_op1", op1, 64'h3000);
        chk("ld_op2", op2, 64'd0);
        chk("ld_rd_w_ena", rd_w_ena, 64'd1);
        chk("ld_illegal", illegal, 64'd0);
        chk("ld32_out_valid", out_valid32, 64'd1);
        chk("ld32_illegal", illegal32, 64'd1);
        chk("ld32_type", inst_type32, 64'd0);
        chk("ld32_rd_w_ena", rd_w_ena32, 64'd0);

        // ---------------- beq x1,x2,-4 -------------------------------------
        inst = 32'hFE20_8EE3; rs1_data = 64'd3; rs2_data = 64'd3;
        tick();
        chk("beq_type", inst_type, 64'h02);
        chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_op2", op2, 64'd3);
        chk("beq_rd_w_ena", rd_w_ena, 64'd0);

        // ---------------- ecall, then a reserved SYSTEM encoding -----------
        inst = 32'h0000_0073;
        tick();
        chk("ecall_type", inst_type, 64'h01);
        chk("ecall_illegal", illegal, 64'd0);
        chk("ecall_rd_w_ena", rd_w_ena, 64'd0);
        inst = 32'h0020_0073;
        tick();
        chk("sys_rsv_illegal", illegal, 64'd1);
        chk("sys_rsv_type", inst_type, 64'd0);

        // ---------------- all-ones word: illegal, never stalls -------------
        inst = 32'hFFFF_FFFF; ex_load_valid = 1'b1; ex_load_rd = 5'd31;
        #1;
        chk("ill_in_ready", in_ready, 64'd1);
        tick();
        chk("ill_out_valid", out_valid, 64'd1);
        chk("ill_illegal", illegal, 64'd1);
        chk("ill_type", inst_type, 64'd0);
        chk("ill_rd_w_ena", rd_w_ena, 64'd0);

        // ---------------- drain --------------------------------------------
        in_valid = 1'b0; ex_load_valid = 1'b0;
        tick();
        chk("drain_out_valid", out_valid, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
